// File: rtl/arb2_rr.sv
// Two-source round-robin arbiter feeding a single registered output slot.
// Optional per-source saturating grant counters are built when ARB2_RR_CNT_EN is defined.
module arb2_rr #(
    parameter int BW_DATA = 4,
    parameter int BW_CNT  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid0,
    input  logic [BW_DATA-1:0] i_in0,
    output logic               o_ready0,
    input  logic               i_valid1,
    input  logic [BW_DATA-1:0] i_in1,
    output logic               o_ready1,
    output logic               o_valid,
    output logic [BW_DATA-1:0] o_data,
    output logic               o_sel,
    input  logic               i_ready,
    output logic [BW_CNT-1:0]  o_cnt0,
    output logic [BW_CNT-1:0]  o_cnt1
);

    typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_t;

    pri_t               state_q, state_d;
    logic               grant0, grant1, ld;
    logic               xfer0, xfer1;
    logic               valid_q, valid_d;
    logic [BW_DATA-1:0] data_q, data_d;
    logic               sel_q, sel_d;

    // The slot can take new data when empty or when its current word drains this cycle.
    assign ld = ~valid_q | i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= PRI0;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ld && grant0)      state_d = PRI1;
        else if (ld && grant1) state_d = PRI0;
    end

    always_comb begin
        grant0   = i_valid0 & (~i_valid1 | (state_q == PRI0));
        grant1   = i_valid1 & (~i_valid0 | (state_q == PRI1));
        o_ready0 = ld & grant0 & ~i_rst;
        o_ready1 = ld & grant1 & ~i_rst;
        xfer0    = o_ready0;
        xfer1    = o_ready1;
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (ld) begin
            valid_d = grant0 | grant1;
            if (grant0) begin
                data_d = i_in0;
                sel_d  = 1'b0;
            end else if (grant1) begin
                data_d = i_in1;
                sel_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_sel   = sel_q;

`ifdef ARB2_RR_CNT_EN
    localparam logic [BW_CNT-1:0] CNT_ONE = {{(BW_CNT-1){1'b0}}, 1'b1};

    logic [BW_CNT-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (xfer0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_ONE;
        if (xfer1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_ONE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign o_cnt0 = cnt0_q;
    assign o_cnt1 = cnt1_q;
`else
    logic unused_xfer;
    assign unused_xfer = xfer0 ^ xfer1;
    assign o_cnt0 = '0;
    assign o_cnt1 = '0;
`endif

endmodule

// File: tb/tb_arb2_rr.sv
// Bench for arb2_rr: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level round-robin model.
module tb_arb2_rr;

    localparam int BW_DATA = 4;
    localparam int BW_CNT  = 2;
    localparam int CNT_MAX = (1 << BW_CNT) - 1;

    logic               clk = 1'b0;
    logic               rst, v0, v1, rdy;
    logic [BW_DATA-1:0] in0, in1;
    logic               r0, r1, ov, osel;
    logic [BW_DATA-1:0] odata;
    logic [BW_CNT-1:0]  c0, c1;

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    arb2_rr #(.BW_DATA(BW_DATA), .BW_CNT(BW_CNT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_valid0(v0), .i_in0(in0), .o_ready0(r0),
        .i_valid1(v1), .i_in1(in1), .o_ready1(r1),
        .o_valid(ov), .o_data(odata), .o_sel(osel), .i_ready(rdy),
        .o_cnt0(c0), .o_cnt1(c1)
    );

    always #5 clk = ~clk;

    // Reference model: the held word, whose turn it is, and how many words each source has sent.
    bit      m_valid = 0;
    int      m_data  = 0;
    int      m_sel   = 0;
    int      m_turn  = 0;
    int      m_cnt[2] = '{0, 0};
    bit      started = 0;

    function automatic int winner();
        if (v0 && v1) return m_turn;
        if (v0)       return 0;
        if (v1)       return 1;
        return -1;
    endfunction

    function automatic bit slot_free();
        return !m_valid || rdy;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        int w;
        started = 1;
        w = winner();
        if (rst) begin
            m_valid = 0; m_data = 0; m_sel = 0; m_turn = 0; m_cnt = '{0, 0};
        end else if (slot_free()) begin
            if (w < 0) m_valid = 0;
            else begin
                m_valid = 1;
                m_data  = (w == 0) ? int'(in0) : int'(in1);
                m_sel   = w;
                m_turn  = 1 - w;
                if (m_cnt[w] < CNT_MAX) m_cnt[w]++;
            end
        end
    end

    // Single compare point, half a cycle away from the active edge.
    always @(negedge clk) begin
        int w;
        if (started) begin
            n_vec++;
            w = winner();
            chk("o_valid", int'(ov), int'(m_valid));
            if (m_valid) begin
                chk("o_data", int'(odata), m_data);
                chk("o_sel", int'(osel), m_sel);
            end
            chk("o_ready0", int'(r0), int'(!rst && slot_free() && w == 0));
            chk("o_ready1", int'(r1), int'(!rst && slot_free() && w == 1));
`ifdef ARB2_RR_CNT_EN
            chk("o_cnt0", int'(c0), m_cnt[0]);
            chk("o_cnt1", int'(c1), m_cnt[1]);
`else
            chk("o_cnt0", int'(c0), 0);
            chk("o_cnt1", int'(c1), 0);
`endif
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_sel[4]  = '{0, 1, 0, 1};
        int exp_dat[4]  = '{3, 10, 3, 10};
        int exp_cnt[5]  = '{1, 2, 3, 3, 3};

        // Reset with both sources requesting.
        rst = 1; v0 = 1; v1 = 1; in0 = 4'h3; in1 = 4'hA; rdy = 1;
        edge1(); edge1();
        chk("rst_o_valid", int'(ov), 0);
        chk("rst_o_data", int'(odata), 0);
        chk("rst_o_sel", int'(osel), 0);
        chk("rst_ready0", int'(r0), 0);
        chk("rst_ready1", int'(r1), 0);
        chk("rst_cnt0", int'(c0), 0);

        // Alternation.
        rst = 0;
        #1 chk("alt_ready0_first", int'(r0), 1);
        for (int i = 0; i < 4; i++) begin
            edge1();
            chk("alt_sel", int'(osel), exp_sel[i]);
            chk("alt_data", int'(odata), exp_dat[i]);
            chk("alt_valid", int'(ov), 1);
        end

        // Single source 1 only.
        v0 = 0; v1 = 1; in1 = 4'h5;
        for (int i = 0; i < 3; i++) begin
            #1 chk("single_ready1", int'(r1), 1);
            edge1();
            chk("single_data", int'(odata), 5);
            chk("single_sel", int'(osel), 1);
        end

        // Backpressure: favoured source is 0 after the single-source run.
        v0 = 1; v1 = 1; in0 = 4'h7; in1 = 4'hA;
        #1 chk("bp_turn_pri0", int'(r0), 1);
        edge1();
        chk("bp_data7", int'(odata), 7);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready0", int'(r0), 0);
            chk("bp_ready1", int'(r1), 0);
            edge1();
            chk("bp_hold", int'(odata), 7);
            chk("bp_hold_valid", int'(ov), 1);
        end
        rdy = 1;
        #1 chk("bp_release_ready1", int'(r1), 1);
        edge1();
        chk("bp_release_sel", int'(osel), 1);
        chk("bp_release_data", int'(odata), 10);

        // Reset while stalled; first grant afterwards goes to source 0.
        rdy = 0;
        edge1();
        rst = 1;
        #1 chk("midrst_ready0", int'(r0), 0);
        chk("midrst_ready1", int'(r1), 0);
        edge1();
        chk("midrst_valid", int'(ov), 0);
        rst = 0; rdy = 1;
        #1 chk("midrst_first_grant", int'(r0), 1);
        edge1();
        chk("midrst_sel", int'(osel), 0);

        // Counter saturation with back-to-back source-0 traffic.
        rst = 1;
        edge1();
        rst = 0; v0 = 1; v1 = 0; in0 = 4'h1;
        for (int i = 0; i < 5; i++) begin
            edge1();
`ifdef ARB2_RR_CNT_EN
            chk("cnt0_sat", int'(c0), exp_cnt[i]);
`else
            chk("cnt0_off", int'(c0), 0);
            if (exp_cnt[i] < 0) chk("cnt_table", exp_cnt[i], 0);
`endif
            chk("cnt1_zero", int'(c1), 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 99) < 2);
            v0  = $urandom_range(0, 1);
            v1  = $urandom_range(0, 1);
            in0 = BW_DATA'($urandom);
            in1 = BW_DATA'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
        end
        edge1();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
